// File: rtl/pc_gen_pkg.sv
// Shared definitions for the IF-stage fetch-address generator:
// FSM state encoding, default reset vector and PC step.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'hBFC0_0000;
    localparam int unsigned PC_INC           = 4;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a branch redirect that arrived while fetch could not advance,
// until the next grant consumes it or a flush discards it.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              advance,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr
);

    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_addr;

    // A newer branch always overwrites an older pending one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
        end else if (flush) begin
            r_pend_valid <= 1'b0;
        end else if (branch_flag && !advance) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= branch_addr;
        end else if (advance) begin
            r_pend_valid <= 1'b0;
        end
    end

    assign pend_valid = r_pend_valid;
    assign pend_addr  = r_pend_addr;

endmodule

// File: rtl/pc_gen.sv
// IF-stage PC generator: req/gnt fetch to the instruction ROM, delayed-branch redirect,
// stall and flush. Define PC_ALIGN_CHECK_EN to enable misaligned-target detection.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_gnt,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              addr_err,
    output state_t            dbg_state
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_if_pc;
    logic              r_if_valid;

    logic              w_pend_valid;
    logic [ADDR_W-1:0] w_pend_addr;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_redirect;
    logic              w_inst_req;
    logic              w_advance;
    logic              w_lock;
    logic              w_addr_err;

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .branch_flag (branch_flag),
        .branch_addr (branch_addr),
        .advance     (w_advance),
        .pend_valid  (w_pend_valid),
        .pend_addr   (w_pend_addr)
    );

    assign w_inst_req = (r_state == S_FETCH) && !stall && !w_lock;
    assign w_advance  = w_inst_req && inst_gnt;

    // A branch seen without a grant only fills the redirect buffer; pc stays.
    always_comb begin
        w_next_pc  = r_pc;
        w_redirect = 1'b0;
        if (flush) begin
            w_next_pc  = exc_pc;
            w_redirect = 1'b1;
        end else if (branch_flag && w_advance) begin
            w_next_pc  = branch_addr;
            w_redirect = 1'b1;
        end else if (!branch_flag && w_pend_valid && w_advance) begin
            w_next_pc  = w_pend_addr;
            w_redirect = 1'b1;
        end else if (!branch_flag && w_advance) begin
            w_next_pc  = r_pc + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RESET;
            r_pc       <= RESET_PC;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_if_valid <= w_advance && !flush;
            if (w_advance) begin
                r_if_pc <= r_pc;
            end
            case (r_state)
                S_RESET: r_state <= S_FETCH;
                S_FETCH: r_state <= (stall && !flush) ? S_HOLD : S_FETCH;
                S_HOLD:  r_state <= (!stall || flush) ? S_FETCH : S_HOLD;
                default: r_state <= S_RESET;
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_lock;
    logic r_addr_err;

    // Fetch stays parked on a misaligned target until a flush supplies a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_redirect && is_misaligned(w_next_pc[1:0]);
            if (w_redirect && is_misaligned(w_next_pc[1:0])) begin
                r_lock <= 1'b1;
            end else if (flush) begin
                r_lock <= 1'b0;
            end
        end
    end

    assign w_lock     = r_lock;
    assign w_addr_err = r_addr_err;
`else
    assign w_lock     = 1'b0;
    assign w_addr_err = 1'b0;
`endif

    assign inst_req  = w_inst_req;
    assign inst_addr = r_pc;
    assign if_pc     = r_if_pc;
    assign if_valid  = r_if_valid;
    assign addr_err  = w_addr_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model of the fetch rules.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam logic [31:0] RPC = 32'hBFC0_0000;
    localparam int PH_RST   = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] exc_pc = 32'h0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        inst_gnt = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        addr_err;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_phase;
    logic [31:0] m_pc;
    bit          m_pv;
    logic [31:0] m_pa;
    bit          m_if_valid;
    logic [31:0] m_if_pc;
    bit          m_err;
    bit          m_lock;

    pc_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .exc_pc      (exc_pc),
        .branch_flag (branch_flag),
        .branch_addr (branch_addr),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .addr_err    (addr_err),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic bit exp_req();
        return rst_n && (m_phase == PH_FETCH) && !stall && !m_lock;
    endfunction

    task automatic model_reset();
        m_phase    = PH_RST;
        m_pc       = RPC;
        m_pv       = 1'b0;
        m_pa       = 32'h0;
        m_if_valid = 1'b0;
        m_if_pc    = 32'h0;
        m_err      = 1'b0;
        m_lock     = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit adv;
        bit redir;
        adv = exp_req() && inst_gnt;
        redir = 1'b0;
        m_if_valid = adv && !flush;
        if (adv) m_if_pc = m_pc;
        if (flush) begin
            m_pc = exc_pc; m_pv = 1'b0; redir = 1'b1;
        end else if (branch_flag && adv) begin
            m_pc = branch_addr; m_pv = 1'b0; redir = 1'b1;
        end else if (branch_flag) begin
            m_pa = branch_addr; m_pv = 1'b1;
        end else if (m_pv && adv) begin
            m_pc = m_pa; m_pv = 1'b0; redir = 1'b1;
        end else if (adv) begin
            m_pc = m_pc + 32'd4;
        end
        m_err = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        if (flush) m_lock = 1'b0;
        if (redir && (m_pc % 4 != 0)) begin
            m_err  = 1'b1;
            m_lock = 1'b1;
        end
`endif
        if (m_phase == PH_RST) m_phase = PH_FETCH;
        else if (flush) m_phase = PH_FETCH;
        else if (m_phase == PH_FETCH && stall) m_phase = PH_HOLD;
        else if (m_phase == PH_HOLD && !stall) m_phase = PH_FETCH;
    endtask

    task automatic compare_all();
        chk1("inst_req", inst_req, exp_req());
        chk("inst_addr", inst_addr, m_pc);
        chk1("if_valid", if_valid, m_if_valid);
        chk("if_pc", if_pc, m_if_pc);
        chk1("addr_err", addr_err, m_err);
        chk1("pend_valid", dut.w_pend_valid, m_pv);
    endtask

    // One cycle: drive at the falling edge, check 1ns later, then model the rising edge.
    task automatic step(input bit g = 1'b0, input bit st = 1'b0, input bit bf = 1'b0,
                        input logic [31:0] ba = 32'h0, input bit fl = 1'b0,
                        input logic [31:0] ep = 32'h0, input bit rn = 1'b1);
        @(negedge clk);
        rst_n = rn; inst_gnt = g; stall = st; branch_flag = bf;
        branch_addr = ba; flush = fl; exc_pc = ep;
        #1;
        if (!rst_n) model_reset();
        compare_all();
        if (rst_n) model_step();
    endtask

    initial begin
        logic [31:0] ba;
        logic [31:0] ep;
        model_reset();

        // reset and first fetches with grant held high
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_addr", inst_addr, 32'hBFC0_0000);
        chk1("reset_req", inst_req, 1'b0);
        step(1);
        chk1("sreset_req", inst_req, 1'b0);
        step(1);
        chk("seq0", inst_addr, 32'hBFC0_0000);
        step(1);
        chk("seq1", inst_addr, 32'hBFC0_0004);
        chk1("first_valid", if_valid, 1'b1);
        chk("first_if_pc", if_pc, 32'hBFC0_0000);
        step(1);
        chk("seq2", inst_addr, 32'hBFC0_0008);

        // taken branch with grant: 0x100 is the delay slot
        step(0, 0, 0, 0, 1, 32'h100);
        step(1, 0, 1, 32'h2000);
        step(0);
        chk("br_target", inst_addr, 32'h2000);
        chk1("dslot_valid", if_valid, 1'b1);
        chk("dslot_pc", if_pc, 32'h100);

        // branch during a wait for grant is deferred
        step(0, 0, 0, 0, 1, 32'h200);
        step(0, 0, 1, 32'h3000);
        step(0);
        step(0);
        chk("pend_hold_addr", inst_addr, 32'h200);
        chk1("pend_set", dut.w_pend_valid, 1'b1);
        step(1);
        step(0);
        chk("pend_target", inst_addr, 32'h3000);
        chk1("pend_clr", dut.w_pend_valid, 1'b0);

        // stall for 4 cycles
        step(0, 0, 0, 0, 1, 32'h400);
        for (int i = 0; i < 4; i++) begin
            step(1, 1);
            chk1("stall_req", inst_req, 1'b0);
            chk("stall_addr", inst_addr, 32'h400);
        end
        step(0);
        chk("unstall_addr", inst_addr, 32'h400);
        step(1);
        step(0);
        chk("unstall_next", inst_addr, 32'h404);

        // flush with stall and a pending branch
        step(0, 0, 1, 32'h5000);
        step(1, 1, 0, 0, 1, 32'hBFC0_0380);
        step(1, 1);
        chk("flush_pc", inst_addr, 32'hBFC0_0380);
        chk1("flush_pend", dut.w_pend_valid, 1'b0);
        chk1("flush_novalid", if_valid, 1'b0);
        step(0);
        step(0, 0, 1, 32'h6000);
        step(1, 0, 0, 0, 1, 32'h800);
        step(0);
        chk1("abort_novalid", if_valid, 1'b0);
        chk("abort_pc", inst_addr, 32'h800);

        // reset while a request is waiting for grant
        step(0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk1("midrst_req", inst_req, 1'b0);
        chk("midrst_addr", inst_addr, 32'hBFC0_0000);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1);

`ifdef PC_ALIGN_CHECK_EN
        step(0, 0, 0, 0, 1, 32'h1000);
        step(1, 0, 1, 32'h1002);
        step(1);
        chk1("align_err_pulse", addr_err, 1'b1);
        chk1("align_lock_req", inst_req, 1'b0);
        step(1);
        chk1("align_err_drop", addr_err, 1'b0);
        chk1("align_lock_req2", inst_req, 1'b0);
        step(1, 0, 0, 0, 1, 32'h1100);
        step(0);
        chk1("align_unlock", inst_req, 1'b1);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            ba = $urandom() & 32'hFFFF_FFFC;
            ep = $urandom() & 32'hFFFF_FFFC;
`ifdef PC_ALIGN_CHECK_EN
            if ($urandom_range(0, 7) == 0) ba[1:0] = 2'($urandom_range(1, 3));
`endif
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, ba, $urandom_range(0, 9) == 0, ep);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- IF-stage fetch-address generator. It is the consumer of the ID-stage branch-resolution outputs (branch_flag/branch_addr).
- Holds the PC and issues fetch requests to the instruction ROM port with a req/gnt handshake.
- Applies branch redirects after the delay slot, defers redirects that arrive while fetch cannot advance, and honours stall and exception flush.
- Feeds the fetched PC and a valid strobe to the IF/ID register.

Parameters:
- ADDR_W, 32, width of all address signals (matches `ADDR_BUS`).
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline-control stall for IF.
- flush  in  1  exception/eret flush.
- exc_pc  in  ADDR_W  flush target.
- branch_flag  in  1  ID-stage taken-branch/jump indication.
- branch_addr  in  ADDR_W  ID-stage branch target.
- inst_req  out  1  fetch request to ROM.
- inst_addr  out  ADDR_W  fetch address to ROM.
- inst_gnt  in  1  ROM accepts the request this cycle.
- if_pc  out  ADDR_W  PC of the instruction whose data arrives this cycle.
- if_valid  out  1  if_pc and ROM data are valid.
- addr_err  out  1  misaligned fetch target (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_RESET, pend_valid=0, pend_addr=0.
  - if_pc=0, if_valid=0, addr_err=0.
  - inst_req=0 while in reset and in S_RESET.
- States:
  - S_RESET: one cycle after reset release, then go to S_FETCH.
  - S_FETCH: inst_req = !stall. Go to S_HOLD when stall=1.
  - S_HOLD: inst_req=0 and pc held. Return to S_FETCH when stall=0.
  - flush forces S_FETCH from any state except S_RESET.
- inst_addr=pc, combinational. While inst_req=1 and inst_gnt=0, inst_addr stays stable unless flush=1.
- advance = inst_req & inst_gnt.
- Next-pc priority, evaluated each cycle:
  1. flush: pc<=exc_pc and pend_valid<=0. Applies regardless of advance, and aborts any ungranted request.
  2. branch_flag & advance: pc<=branch_addr. The instruction granted this cycle is the delay slot. pend_valid<=0.
  3. branch_flag & !advance: pend_addr<=branch_addr, pend_valid<=1, pc unchanged. A newer branch_flag overwrites a pending one.
  4. pend_valid & advance: pc<=pend_addr, pend_valid<=0.
  5. advance: pc<=pc+4, wrapping modulo 2^ADDR_W.
  6. Otherwise pc holds.
- Fetch response (ROM is synchronous, data one cycle after grant):
  - if_valid<=advance & !flush.
  - if_pc<=pc when advance.
  - A flush in the grant cycle suppresses the following if_valid.
- Latency:
  - RESET_PC appears on inst_addr in the cycle after rst_n rises.
  - Redirect targets appear on inst_addr in the cycle after the advance (or flush) that accepts them.
- stall and flush in the same cycle: flush wins, pc<=exc_pc. The state goes to S_HOLD if stall persists next cycle.
- Reset asserted mid-transaction: everything returns to reset values immediately, and the outstanding request is dropped.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect target (branch_addr, pend_addr or exc_pc) with bits [1:0]!=0 sets addr_err=1 for exactly one cycle, registered with the pc update.
  - pc still loads the target, but inst_req is held 0 until the next flush.
- Undefined: addr_err is tied 0 and no check logic is generated.

Decomposition:
- Shared package/header: state encodings S_RESET/S_FETCH/S_HOLD, RESET_PC default, PC increment constant 4.
- These sit alongside the existing bus macros.
- One natural sub-module: pc_redirect_buf, which holds pend_valid/pend_addr and the branch-overwrite/clear logic.
- Keep the FSM and pc register in pc_gen.

Test Plan:
- Release reset, hold inst_gnt=1 → inst_addr sequence BFC00000, BFC00004, BFC00008. if_valid rises one cycle after the first grant, with if_pc=BFC00000.
- While fetching 0x100 with gnt=1, pulse branch_flag with branch_addr=0x2000 → next inst_addr=0x2000. The 0x100 delay slot is delivered with if_valid=1.
- branch_flag with addr 0x3000 while gnt=0 for 3 cycles → inst_addr stays 0x200 and pend_valid=1. On the grant, next inst_addr=0x3000 and pend_valid clears.
- stall=1 for 4 cycles at pc=0x400 → inst_req=0 and pc held. After release, inst_addr=0x400 and then 0x404 once granted.
- flush with exc_pc=0xBFC00380 simultaneous with stall and a pending branch → pc=0xBFC00380, pending cleared, and no if_valid for the aborted fetch.
- With PC_ALIGN_CHECK_EN defined, branch_addr=0x1002 → addr_err pulses for one cycle and inst_req stays 0 until flush. Without the macro, addr_err=0 always.
